// File: rtl/alu_pkg.sv
// Shared widths, opcode encodings and FSM state encoding for the ALU arbiter.
package alu_pkg;

   localparam int DATA_WIDTH   = 36;
   localparam int ALU_OP_WIDTH = 3;

   localparam logic [ALU_OP_WIDTH-1:0] OP_ADD = 3'b000;
   localparam logic [ALU_OP_WIDTH-1:0] OP_SUB = 3'b001;
   localparam logic [ALU_OP_WIDTH-1:0] OP_AND = 3'b010;
   localparam logic [ALU_OP_WIDTH-1:0] OP_OR  = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   // Opcodes with the top bit set are reserved and must produce a zero result.
   function automatic logic op_supported(input logic [ALU_OP_WIDTH-1:0] op);
      return (op[ALU_OP_WIDTH-1] == 1'b0);
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: ADD/SUB wrap modulo 2^DATA_WIDTH, bitwise AND/OR, else zero.
module alu #(
   parameter int DATA_WIDTH   = alu_pkg::DATA_WIDTH,
   parameter int ALU_OP_WIDTH = alu_pkg::ALU_OP_WIDTH
) (
   input  logic [DATA_WIDTH-1:0]   a_i,
   input  logic [DATA_WIDTH-1:0]   b_i,
   input  logic [ALU_OP_WIDTH-1:0] op_i,
   output logic [DATA_WIDTH-1:0]   y_o
);
   import alu_pkg::*;

   always_comb begin
      y_o = {DATA_WIDTH{1'b0}};
      case (op_i)
         OP_ADD:  y_o = a_i + b_i;
         OP_SUB:  y_o = a_i - b_i;
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         default: y_o = {DATA_WIDTH{1'b0}};
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU; one operation in flight,
// IDLE -> EXEC -> RESP, response held until the granted requester consumes it.
module alu_arbiter #(
   parameter int DATA_WIDTH   = alu_pkg::DATA_WIDTH,
   parameter int ALU_OP_WIDTH = alu_pkg::ALU_OP_WIDTH
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_req0_valid,
   output logic                    o_req0_ready,
   input  logic [DATA_WIDTH-1:0]   i_req0_a,
   input  logic [DATA_WIDTH-1:0]   i_req0_b,
   input  logic [ALU_OP_WIDTH-1:0] i_req0_op,
   input  logic                    i_req1_valid,
   output logic                    o_req1_ready,
   input  logic [DATA_WIDTH-1:0]   i_req1_a,
   input  logic [DATA_WIDTH-1:0]   i_req1_b,
   input  logic [ALU_OP_WIDTH-1:0] i_req1_op,
   output logic                    o_rsp0_valid,
   input  logic                    i_rsp0_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp0_result,
   output logic                    o_rsp1_valid,
   input  logic                    i_rsp1_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp1_result,
   output logic                    o_busy
);
   import alu_pkg::*;

   state_e                  state_q, state_d;
   logic                    gnt_q, gnt_d;
   logic                    last_q, last_d;
   logic [DATA_WIDTH-1:0]   a_q, a_d;
   logic [DATA_WIDTH-1:0]   b_q, b_d;
   logic [ALU_OP_WIDTH-1:0] op_q, op_d;
   logic [DATA_WIDTH-1:0]   result_q, result_d;
   logic [DATA_WIDTH-1:0]   alu_y_s;
   logic                    ready0_s, ready1_s;
   logic                    rsp_taken_s;

   alu #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ALU_OP_WIDTH(ALU_OP_WIDTH)
   ) u_alu (
      .a_i (a_q),
      .b_i (b_q),
      .op_i(op_q),
      .y_o (alu_y_s)
   );

   assign rsp_taken_s = (gnt_q == 1'b0) ? i_rsp0_ready : i_rsp1_ready;

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      ready0_s = 1'b0;
      ready1_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Requester 0 wins a tie only when requester 1 was granted last.
            if (i_req0_valid && (!i_req1_valid || last_q)) begin
               ready0_s = 1'b1;
               gnt_d    = 1'b0;
               last_d   = 1'b0;
               a_d      = i_req0_a;
               b_d      = i_req0_b;
               op_d     = i_req0_op;
               state_d  = ST_EXEC;
            end else if (i_req1_valid) begin
               ready1_s = 1'b1;
               gnt_d    = 1'b1;
               last_d   = 1'b1;
               a_d      = i_req1_a;
               b_d      = i_req1_b;
               op_d     = i_req1_op;
               state_d  = ST_EXEC;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (op_supported(op_q)) begin
               result_d = alu_y_s;
            end else begin
               result_d = {DATA_WIDTH{1'b0}};
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_taken_s) begin
               result_d = {DATA_WIDTH{1'b0}};
               state_d  = ST_IDLE;
            end else begin
               state_d  = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         gnt_q    <= 1'b0;
         last_q   <= 1'b1;
         a_q      <= {DATA_WIDTH{1'b0}};
         b_q      <= {DATA_WIDTH{1'b0}};
         op_q     <= {ALU_OP_WIDTH{1'b0}};
         result_q <= {DATA_WIDTH{1'b0}};
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
      end
   end

   assign o_req0_ready  = ready0_s;
   assign o_req1_ready  = ready1_s;
   assign o_busy        = (state_q != ST_IDLE);
   assign o_rsp0_valid  = (state_q == ST_RESP) && (gnt_q == 1'b0);
   assign o_rsp1_valid  = (state_q == ST_RESP) && (gnt_q == 1'b1);
   assign o_rsp0_result = o_rsp0_valid ? result_q : {DATA_WIDTH{1'b0}};
   assign o_rsp1_result = o_rsp1_valid ? result_q : {DATA_WIDTH{1'b0}};

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 36, operand/result width.
REQ-002 Parameter ALU_OP_WIDTH, 3, opcode width.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_req0_valid  input  1  requester 0 has an operation pending.
REQ-006 o_req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 i_req0_a, i_req0_b  input  DATA_WIDTH  requester 0 operands.
REQ-008 i_req0_op  input  ALU_OP_WIDTH  requester 0 opcode.
REQ-009 i_req1_valid, o_req1_ready, i_req1_a, i_req1_b, i_req1_op  same as REQ-005..008 for requester 1.
REQ-010 o_rsp0_valid  output  1  result for requester 0 available.
REQ-011 i_rsp0_ready  input  1  requester 0 consumes result.
REQ-012 o_rsp0_result  output  DATA_WIDTH  requester 0 result.
REQ-013 o_rsp1_valid, i_rsp1_ready, o_rsp1_result  same as REQ-010..012 for requester 1.
REQ-014 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM SHALL have states IDLE, EXEC, RESP.
REQ-016 IDLE: if any i_reqN_valid, grant one requester, assert its o_reqN_ready combinationally that cycle, latch its a/b/op and grant id, go EXEC; else stay IDLE.
REQ-017 o_reqN_ready SHALL be high only in IDLE, only for the granted requester, only while its valid is high; never both high.
REQ-018 Arbitration SHALL be round-robin: on simultaneous valids, grant the requester not granted last; last-granted pointer updates on each grant.
REQ-019 EXEC: latched operands drive the shared ALU; result registered at end of EXEC; go RESP.
REQ-020 RESP: o_rspN_valid high for the granted requester only, o_rspN_result holds the registered result; on i_rspN_ready high go IDLE next cycle; otherwise hold valid and result stable indefinitely.
REQ-021 Latency: accept at cycle N -> o_rspN_valid high at cycle N+2; minimum 3 cycles per operation.
REQ-022 Opcodes: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR; 100-111 SHALL yield result 0.
REQ-023 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH; no carry/overflow flag.
REQ-024 Requester valid SHALL be sampled only in IDLE; valids asserted during EXEC/RESP wait and are not dropped by the arbiter.
REQ-025 i_rspN_ready for a requester not being responded to SHALL be ignored.
REQ-026 o_rspN_result for the non-granted requester SHALL read 0.

Reset
REQ-027 On i_rst high, asynchronously: state IDLE, all o_*_valid/o_*_ready/o_busy 0, results 0, operand registers 0, last-granted pointer = requester 1 (requester 0 wins first tie).
REQ-028 Reset during EXEC or RESP SHALL discard the in-flight operation with no response issued.

Structure
REQ-029 Shared package alu_pkg SHALL hold DATA_WIDTH, ALU_OP_WIDTH, opcode constants ADD/SUB/AND/OR and the FSM state encoding.
REQ-030 Existing combinational module alu SHALL be instantiated once as the sole sub-module; arbiter adds no arithmetic of its own besides the unsupported-opcode zeroing.

Verification
REQ-031 req0 only, a=435 b=245 op=000 -> ready at cycle 0, o_rsp0_valid at cycle 2, result 0x0000002A8.
REQ-032 req0 (5-6, op 001) and req1 (8|11, op 011) valid same cycle after reset -> req0 first, result 0xFFFFFFFFF; then req1, result 0x00000000B; o_req1_ready never high while o_busy.
REQ-033 Backpressure: hold i_rsp0_ready low 5 cycles after 2&7 (op 010) -> o_rsp0_valid and result 0x000000002 stable for all 5 cycles, IDLE one cycle after ready.
REQ-034 Overflow: 68719476735+1 op 000 -> result 0x000000000; op 111 with a=1 b=1 -> result 0.
REQ-035 Assert i_rst during EXEC -> all outputs 0 immediately, no o_rspN_valid afterwards, next request served normally with latency 2.
